dsp_mac_sequencer: RTL

Frame-based multiply-accumulate sequencer that drives one `dsp_t1_20x18x64` instance in accumulate mode. It accepts a stream of operand pairs grouped into frames, issues them to the DSP with correct `load_acc` framing, and waits out the DSP pipeline latency. It then returns one 38-bit dot-product result per frame on a valid/ready output. It sits between a stream producer (FIR/matrix front end) and the DSP primitive. It owns every DSP control pin except `clock_i`/`reset_i`, which are shared.

---
 rtl/dsp_seq_pkg.sv | 17 +
 rtl/dsp_mac_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP multiply-accumulate frame sequencer.
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } dsp_seq_state_t;

  localparam int DSP_A_W = 20;
  localparam int DSP_B_W = 18;
  localparam int DSP_Z_W = 38;

  localparam logic [2:0] DSP_FEEDBACK_ACC = 3'd0;

endpackage

// File: rtl/dsp_mac_sequencer.sv
// Frame sequencer for a DSP in accumulate mode: issues operand beats with load_acc
// framing, waits out the DSP latency and returns one dot product per frame.
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int DSP_LATENCY = 1,
  parameter int LEN_W       = 16
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [DSP_A_W-1:0] in_a_i,
  input  logic [DSP_B_W-1:0] in_b_i,
  input  logic               in_sub_i,
  input  logic               in_last_i,
  input  logic               in_unsigned_a_i,
  input  logic               in_unsigned_b_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DSP_Z_W-1:0] out_z_o,
  output logic [LEN_W-1:0]   out_len_o,
  output logic               busy_o,
  output logic [DSP_A_W-1:0] dsp_a_o,
  output logic [DSP_B_W-1:0] dsp_b_o,
  output logic               dsp_load_acc_o,
  output logic               dsp_subtract_o,
  output logic               dsp_unsigned_a_o,
  output logic               dsp_unsigned_b_o,
  output logic [2:0]         dsp_feedback_o,
  input  logic [DSP_Z_W-1:0] dsp_z_i
);

  dsp_seq_state_t     state_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   out_len_q;
  logic [2:0]         drain_q;
  logic               uns_a_q;
  logic               uns_b_q;
  logic [DSP_Z_W-1:0] out_z_q;
  logic               accept;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + LEN_W'(1);
  endfunction

  assign in_ready_o     = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
  assign accept         = in_valid_i && in_ready_o;
  assign out_valid_o    = (state_q == ST_HOLD);
  assign busy_o         = (state_q != ST_IDLE);
  assign out_z_o        = out_z_q;
  assign out_len_o      = out_len_q;
  assign dsp_feedback_o = DSP_FEEDBACK_ACC;

  // Operand path is combinational so the DSP sees a beat in its accept cycle;
  // unaccepted cycles feed a zero product so gaps leave the accumulator intact.
  always_comb begin
    dsp_a_o          = '0;
    dsp_b_o          = '0;
    dsp_subtract_o   = 1'b0;
    dsp_load_acc_o   = 1'b0;
    dsp_unsigned_a_o = 1'b0;
    dsp_unsigned_b_o = 1'b0;
    if (accept) begin
      dsp_a_o        = in_a_i;
      dsp_b_o        = in_b_i;
      dsp_subtract_o = in_sub_i;
      dsp_load_acc_o = (state_q == ST_IDLE);
    end
    unique case (state_q)
      ST_IDLE: begin
        dsp_unsigned_a_o = accept && in_unsigned_a_i;
        dsp_unsigned_b_o = accept && in_unsigned_b_i;
      end
      ST_ACCUM, ST_DRAIN: begin
        dsp_unsigned_a_o = uns_a_q;
        dsp_unsigned_b_o = uns_b_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      drain_q   <= '0;
      uns_a_q   <= 1'b0;
      uns_b_q   <= 1'b0;
      out_z_q   <= '0;
      out_len_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            uns_a_q <= in_unsigned_a_i;
            uns_b_q <= in_unsigned_b_i;
            len_q   <= LEN_W'(1);
            drain_q <= 3'd1;
            state_q <= in_last_i ? ST_DRAIN : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            len_q   <= sat_inc(len_q);
            drain_q <= 3'd1;
            if (in_last_i) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // drain_q counts cycles since the last beat; at DSP_LATENCY the
          // final product has reached dsp_z_i.
          if (drain_q == 3'(DSP_LATENCY)) begin
            out_z_q   <= dsp_z_i;
            out_len_q <= len_q;
            state_q   <= ST_HOLD;
          end else begin
            drain_q <= drain_q + 3'd1;
          end
        end
        ST_HOLD: begin
          if (out_ready_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
